fifo_ctrl: RTL

Single-clock FIFO controller that sequences the team's 2**DEPTH-entry register-file memory (synchronous write, combinational read). It owns the read/write pointers, exposes ready/valid handshakes to a producer and a consumer, and drives the memory's write-enable, write-full guard and both addresses. Read data is first-word-fall-through straight from the memory's combinational read port.

---
 rtl/fifo_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller for a 2**DEPTH-entry register-file memory.
// Owns the read/write pointers; read data falls through from the memory's combinational port.
module fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = 2**DEPTH - 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic             mem_we,
  output logic             mem_wfull,
  output logic [DEPTH-1:0] mem_waddr,
  output logic [DEPTH-1:0] mem_raddr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam logic [DEPTH:0] L_AFULL = (DEPTH+1)'(AFULL);
  localparam logic [DEPTH:0] L_ONE   = (DEPTH+1)'(1);

  logic [DEPTH:0] r_wptr;
  logic [DEPTH:0] r_rptr;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [DEPTH:0] w_count;

  // One extra pointer bit distinguishes full from empty when the addresses match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH] != r_rptr[DEPTH]) &&
                   (r_wptr[DEPTH-1:0] == r_rptr[DEPTH-1:0]);
  assign w_count = r_wptr - r_rptr;

  assign s_ready = !w_full && !wrst && !flush;
  assign w_push  = s_valid && s_ready;
  assign m_valid = !w_empty;
  assign w_pop   = m_valid && m_ready;

  assign mem_we      = w_push;
  assign mem_wfull   = w_full;
  assign mem_waddr   = r_wptr[DEPTH-1:0];
  assign mem_raddr   = r_rptr[DEPTH-1:0];
  assign mem_wdata   = s_data;
  assign m_data      = mem_rdata;
  assign count       = w_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (w_count >= L_AFULL);

  // Pointer update; flush shares the reset path and suppresses the pop in its cycle.
  always_ff @(posedge wclk) begin
    if (wrst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + L_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + L_ONE;
      end
    end
  end

endmodule
